pitfall_palette_engine: RTL and testbench

Parametrised, programmable successor to the fixed NTSC palette lookup. It maps a pixel colour index from the frame decider to RGB through a double-buffered palette RAM. Software rewrites the RAM at run time, and bank swaps and brightness changes are committed only at frame start. The block sits between frame_decider and the VGA output stage and adds a 2-cycle pipeline, blanking and fade support.

---
 rtl/pitfall_palette_pkg.sv | 40 ++++
 rtl/pitfall_palette_ram.sv | 38 +++
 rtl/pitfall_palette_engine.sv | 156 +++++++++++++++
 tb/tb_pitfall_palette_engine.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pitfall_palette_pkg.sv
// Shared types and helpers for the programmable palette engine:
// FSM state enum, brightness width and the default palette entry.
package pitfall_palette_pkg;

    localparam int BRIGHT_W = 4;
    // Widest channel the default-entry helper can produce.
    localparam int MAX_CH_W = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Replicate a 2-bit field across ch_w bits (01 -> 0x55 for 8 bits).
    function automatic logic [MAX_CH_W-1:0] rep2(
        input logic [1:0] f,
        input int         ch_w
    );
        logic [MAX_CH_W-1:0] r;
        r = '0;
        for (int k = 0; k < MAX_CH_W / 2; k++) begin
            if (k < ch_w / 2) begin
                r[2*k +: 2] = f;
            end
        end
        return r;
    endfunction

    // Default entry {R,G,B}, each channel in a MAX_CH_W-wide slot;
    // callers keep the low ch_w bits of each slot.
    function automatic logic [3*MAX_CH_W-1:0] default_entry(
        input logic [5:0] idx,
        input int         ch_w
    );
        return {rep2(idx[5:4], ch_w),
                rep2(idx[3:2], ch_w),
                rep2(idx[1:0], ch_w)};
    endfunction

endpackage

// File: rtl/pitfall_palette_ram.sv
// Dual-bank palette RAM: one write port (optionally both banks at
// once) and one registered read port with read-before-write behaviour.
// Ports: clk_i; wr_en_i/wr_both_i/wr_bank_i/wr_addr_i/wr_data_i write;
//        rd_bank_i/rd_addr_i read request, rd_data_o one cycle later.
module pitfall_palette_ram #(
    parameter int IDX_W  = 6,
    parameter int DATA_W = 24
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic              wr_both_i,
    input  logic              wr_bank_i,
    input  logic [IDX_W-1:0]  wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_bank_i,
    input  logic [IDX_W-1:0]  rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i && (wr_both_i || !wr_bank_i)) begin
            mem0[wr_addr_i] <= wr_data_i;
        end
        if (wr_en_i && (wr_both_i || wr_bank_i)) begin
            mem1[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= rd_bank_i ? mem1[rd_addr_i] : mem0[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pitfall_palette_engine.sv
// Programmable double-buffered palette: colour index -> RGB in 2 cycles,
// with frame-synchronous bank swap, brightness scaling and blanking.
// Ports: Clk/Reset_n; sof, pix_valid_in/pix_idx/blank pixel input;
//        wr_en/wr_ready/wr_addr/wr_data shadow write; swap_req, bright;
//        init_done, swap_pending status; pix_valid_out/Red/Green/Blue out.
module pitfall_palette_engine
    import pitfall_palette_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int CH_W  = 8
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                sof,
    input  logic                pix_valid_in,
    input  logic [IDX_W-1:0]    pix_idx,
    input  logic                blank,
    input  logic                wr_en,
    output logic                wr_ready,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [3*CH_W-1:0]   wr_data,
    input  logic                swap_req,
    input  logic [BRIGHT_W-1:0] bright,
    output logic                init_done,
    output logic                swap_pending,
    output logic                pix_valid_out,
    output logic [CH_W-1:0]     Red,
    output logic [CH_W-1:0]     Green,
    output logic [CH_W-1:0]     Blue
);

    localparam int DW = 3 * CH_W;
    localparam int PW = CH_W + BRIGHT_W;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic                sel_q, sel_d;
    logic                pend_q, pend_d;
    logic [BRIGHT_W-1:0] bright_q, bright_d;
    logic                v1_q, b1_q;
    logic                vout_q;
    logic [DW-1:0]       rgb_q;

    logic          run;
    logic          pend_eff;
    logic          commit;
    logic [DW-1:0] init_data;
    logic          ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] scaled;
    logic [BRIGHT_W:0] gain;

    assign run      = (state_q == ST_RUN);
    // A swap_req arriving on the sof cycle commits at that same sof.
    assign pend_eff = pend_q | swap_req;
    assign commit   = run & sof & pend_eff;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        pend_d   = pend_q;
        bright_d = bright_q;
        unique case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + {{(IDX_W-1){1'b0}}, 1'b1};
                if (cnt_q == {IDX_W{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sel_d  = sel_q ^ commit;
                pend_d = pend_eff & ~commit;
                if (sof) begin
                    bright_d = bright;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            pend_q   <= 1'b0;
            bright_q <= '1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            pend_q   <= pend_d;
            bright_q <= bright_d;
        end
    end

    assign init_data = {
        CH_W'(default_entry(cnt_q[5:0], CH_W) >> (2 * MAX_CH_W)),
        CH_W'(default_entry(cnt_q[5:0], CH_W) >> MAX_CH_W),
        CH_W'(default_entry(cnt_q[5:0], CH_W))
    };

    // INIT fills both banks; RUN writes only the pre-swap shadow bank,
    // which is the newly active one if a swap commits this cycle.
    assign ram_we    = run ? wr_en : 1'b1;
    assign ram_addr  = run ? wr_addr : cnt_q;
    assign ram_wdata = run ? wr_data : init_data;

    pitfall_palette_ram #(
        .IDX_W  (IDX_W),
        .DATA_W (DW)
    ) u_ram (
        .clk_i     (Clk),
        .wr_en_i   (ram_we),
        .wr_both_i (~run),
        .wr_bank_i (~sel_q),
        .wr_addr_i (ram_addr),
        .wr_data_i (ram_wdata),
        .rd_bank_i (sel_d),
        .rd_addr_i (pix_idx),
        .rd_data_o (rd_data)
    );

    assign gain = {1'b0, bright_q} + {{BRIGHT_W{1'b0}}, 1'b1};

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic [PW-1:0] prod;
        assign prod = PW'(rd_data[ch*CH_W +: CH_W]) * PW'(gain);
        assign scaled[ch*CH_W +: CH_W] = CH_W'(prod >> BRIGHT_W);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v1_q   <= 1'b0;
            b1_q   <= 1'b0;
            vout_q <= 1'b0;
            rgb_q  <= '0;
        end else begin
            v1_q   <= pix_valid_in & run;
            b1_q   <= blank;
            vout_q <= v1_q;
            rgb_q  <= (v1_q && !b1_q) ? scaled : '0;
        end
    end

    assign wr_ready      = run;
    assign init_done     = run;
    assign swap_pending  = pend_q;
    assign pix_valid_out = vout_q;
    assign Red   = rgb_q[3*CH_W-1 -: CH_W];
    assign Green = rgb_q[2*CH_W-1 -: CH_W];
    assign Blue  = rgb_q[CH_W-1 -: CH_W];

endmodule

// File: tb/tb_pitfall_palette_engine.sv
// Self-checking bench for pitfall_palette_engine (IDX_W=6, CH_W=8).
// Fixed vectors, directed corner sequences and a randomised model run.
module tb_pitfall_palette_engine;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        sof = 1'b0;
    logic        pix_valid_in = 1'b0;
    logic [5:0]  pix_idx = '0;
    logic        blank = 1'b0;
    logic        wr_en = 1'b0;
    logic        wr_ready;
    logic [5:0]  wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        swap_req = 1'b0;
    logic [3:0]  bright = 4'hF;
    logic        init_done;
    logic        swap_pending;
    logic        pix_valid_out;
    logic [7:0]  Red, Green, Blue;

    always #5 Clk = ~Clk;

    pitfall_palette_engine #(.IDX_W(6), .CH_W(8)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .sof           (sof),
        .pix_valid_in  (pix_valid_in),
        .pix_idx       (pix_idx),
        .blank         (blank),
        .wr_en         (wr_en),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .swap_req      (swap_req),
        .bright        (bright),
        .init_done     (init_done),
        .swap_pending  (swap_pending),
        .pix_valid_out (pix_valid_out),
        .Red           (Red),
        .Green         (Green),
        .Blue          (Blue)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: two palette banks, active-bank flag, pending flag,
    // captured brightness, INIT progress, and one expected output in flight.
    bit          m_run = 0;
    int          m_icnt = 0;
    bit          m_sel = 0;
    bit          m_pend = 0;
    int          m_bq = 15;
    logic [23:0] mb [2][64];
    bit          pe_v = 0;
    logic [23:0] pe_rgb = '0;

    typedef struct {
        logic [5:0]  idx;
        logic        blk;
        logic [23:0] rgb;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] dflt(input int i);
        int r, g, b;
        r = (i / 16) % 4;
        g = (i / 4) % 4;
        b = i % 4;
        return {8'(r * 85), 8'(g * 85), 8'(b * 85)};
    endfunction

    function automatic logic [23:0] scale(input logic [23:0] c,
                                          input int bq);
        int r, g, b;
        r = int'(c[23:16]) * (bq + 1) / 16;
        g = int'(c[15:8]) * (bq + 1) / 16;
        b = int'(c[7:0]) * (bq + 1) / 16;
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    task automatic model_edge(output bit v, output logic [23:0] e);
        bit pe, cm, ns;
        int nb;
        v = 0;
        e = '0;
        if (!m_run) begin
            m_icnt++;
            if (m_icnt == 64) begin
                for (int i = 0; i < 64; i++) begin
                    mb[0][i] = dflt(i);
                    mb[1][i] = dflt(i);
                end
                m_run = 1;
            end
        end else begin
            pe = m_pend || swap_req;
            cm = sof && pe;
            ns = cm ? !m_sel : m_sel;
            nb = sof ? int'(bright) : m_bq;
            if (pix_valid_in) begin
                v = 1;
                e = blank ? 24'h0 : scale(mb[ns][pix_idx], nb);
            end
            if (wr_en) mb[!m_sel][wr_addr] = wr_data;
            m_sel = ns;
            m_pend = cm ? 1'b0 : pe;
            m_bq = nb;
        end
    endtask

    task automatic tick();
        bit v;
        logic [23:0] e;
        model_edge(v, e);
        @(posedge Clk);
        #1;
        chk("valid_out", pix_valid_out, pe_v);
        if (pe_v) chk("rgb_model", {Red, Green, Blue}, pe_rgb);
        chk("swap_pending", swap_pending, m_pend);
        chk("init_done", init_done, m_run);
        chk("wr_ready", wr_ready, m_run);
        pe_v = v;
        pe_rgb = e;
    endtask

    task automatic idle();
        sof = 0;
        swap_req = 0;
        wr_en = 0;
        pix_valid_in = 0;
        blank = 0;
    endtask

    task automatic pix(input logic [5:0] idx, input logic blk,
                       input logic [23:0] exp, input string nm);
        pix_valid_in = 1;
        pix_idx = idx;
        blank = blk;
        tick();
        pix_valid_in = 0;
        blank = 0;
        tick();
        chk(nm, {Red, Green, Blue}, exp);
        chk({nm, "_valid"}, pix_valid_out, 1);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_valid"}, pix_valid_out, 0);
        chk({nm, "_rgb"}, {Red, Green, Blue}, 0);
        chk({nm, "_init_done"}, init_done, 0);
        chk({nm, "_wr_ready"}, wr_ready, 0);
        chk({nm, "_pending"}, swap_pending, 0);
    endtask

    task automatic rand_cycle();
        sof = ($urandom_range(0, 19) == 0);
        swap_req = ($urandom_range(0, 9) == 0);
        bright = 4'($urandom);
        wr_en = ($urandom_range(0, 2) == 0);
        wr_addr = 6'($urandom);
        wr_data = 24'($urandom);
        pix_valid_in = ($urandom_range(0, 3) != 0);
        pix_idx = 6'($urandom);
        if (wr_en && pix_idx == wr_addr) pix_idx = pix_idx ^ 6'h01;
        blank = ($urandom_range(0, 7) == 0);
        tick();
    endtask

    initial begin
        tbl[0] = '{6'h3F, 1'b0, 24'hFFFFFF};
        tbl[1] = '{6'h05, 1'b0, 24'h005555};
        tbl[2] = '{6'h20, 1'b0, 24'hAA0000};
        tbl[3] = '{6'h3F, 1'b1, 24'h000000};
        tbl[4] = '{6'h2A, 1'b0, 24'hAAAAAA};
        tbl[5] = '{6'h1B, 1'b0, 24'h55AAFF};

        #1;
        check_zero("reset");
        @(posedge Clk);
        #1;
        Reset_n = 1;

        // INIT: writes, swaps, sof and pixels must all be ignored.
        wr_en = 1;
        wr_addr = 6'h05;
        wr_data = 24'hDEADBE;
        pix_valid_in = 1;
        pix_idx = 6'h3F;
        swap_req = 1;
        sof = 1;
        for (int i = 0; i < 63; i++) begin
            tick();
            chk("init_rgb", {Red, Green, Blue}, 0);
        end
        chk("init_done_at_63", init_done, 0);
        tick();
        chk("init_done_at_64", init_done, 1);
        idle();
        tick();
        chk("init_pixels_dropped", pix_valid_out, 0);

        for (int i = 0; i < 6; i++) begin
            pix(tbl[i].idx, tbl[i].blk, tbl[i].rgb, $sformatf("tbl%0d", i));
        end

        // Shadow write becomes visible only from the committing sof.
        wr_en = 1;
        wr_addr = 6'h05;
        wr_data = 24'h123456;
        tick();
        idle();
        swap_req = 1;
        tick();
        swap_req = 0;
        chk("pending_after_req", swap_pending, 1);
        pix(6'h05, 0, 24'h005555, "pre_sof");
        chk("pending_held", swap_pending, 1);
        sof = 1;
        pix_valid_in = 1;
        pix_idx = 6'h05;
        tick();
        idle();
        chk("pending_cleared", swap_pending, 0);
        tick();
        chk("sof_cycle_pix", {Red, Green, Blue}, 24'h123456);
        pix(6'h05, 0, 24'h123456, "post_sof");

        // Brightness captured at sof only.
        bright = 4'd7;
        sof = 1;
        tick();
        sof = 0;
        pix(6'h3F, 0, 24'h7F7F7F, "bright7");
        bright = 4'd3;
        pix(6'h3F, 0, 24'h7F7F7F, "bright_mid_frame");
        pix(6'h3F, 1, 24'h000000, "blank");
        bright = 4'hF;
        sof = 1;
        tick();
        sof = 0;
        pix(6'h3F, 0, 24'hFFFFFF, "bright15");

        // Write on the committing sof lands in the newly active bank.
        swap_req = 1;
        tick();
        swap_req = 0;
        sof = 1;
        wr_en = 1;
        wr_addr = 6'h09;
        wr_data = 24'hABCDEF;
        tick();
        idle();
        pix(6'h09, 0, 24'hABCDEF, "wr_on_swap");
        pix(6'h05, 0, 24'h005555, "bank0_idx5");

        // Repeated swap_req while pending: a single toggle.
        swap_req = 1;
        tick();
        tick();
        swap_req = 0;
        sof = 1;
        tick();
        sof = 0;
        pix(6'h05, 0, 24'h123456, "dbl_swap_idx5");
        pix(6'h09, 0, 24'h00AA55, "dbl_swap_idx9");

        for (int i = 0; i < 300; i++) rand_cycle();

        // Asynchronous reset in the middle of streaming.
        pix_valid_in = 1;
        pix_idx = 6'h3F;
        blank = 0;
        tick();
        tick();
        chk("pre_reset_valid", pix_valid_out, 1);
        #3;
        Reset_n = 0;
        #1;
        check_zero("async_reset");
        m_run = 0;
        m_icnt = 0;
        m_sel = 0;
        m_pend = 0;
        m_bq = 15;
        pe_v = 0;
        @(posedge Clk);
        #1;
        Reset_n = 1;
        for (int i = 0; i < 64; i++) rand_cycle();
        idle();
        bright = 4'hF;
        tick();
        pix(6'h05, 0, 24'h005555, "reset_default5");
        pix(6'h09, 0, 24'h00AA55, "reset_default9");

        for (int i = 0; i < 300; i++) rand_cycle();
        idle();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
